// File: rtl/counter.sv
// rtl/counter.sv - WIDTH-bit synchronous up-counter built from a T-flip-flop chain
//
// counter_tff: one T stage; flips on a falling edge of clock when toggle_i is 1.
//   clock    in  1  stage clock, falling-edge active
//   clear    in  1  synchronous active-high clear, wins over toggle_i
//   toggle_i in  1  toggle enable
//   q_o      out 1  stage value
//
// counter: free-running wrap-around counter, equivalent to a falling-edge ripple
// counter but with every stage on the same clock.
//   Q        out WIDTH  registered count
//   clock    in  1      falling-edge active clock
//   clear    in  1      synchronous active-high clear, sampled at the falling edge

module counter_tff (
  input  logic clock,
  input  logic clear,
  input  logic toggle_i,
  output logic q_o
);

  logic t_q;
  logic t_d;

  always_comb begin
    t_d = t_q;
    if (toggle_i) begin
      t_d = ~t_q;
    end
  end

  always_ff @(negedge clock) begin
    if (clear) begin
      t_q <= 1'b0;
    end else begin
      t_q <= t_d;
    end
  end

  assign q_o = t_q;

endmodule

module counter #(
  parameter int WIDTH = 4
) (
  output logic [WIDTH-1:0] Q,
  input  logic             clock,
  input  logic             clear
);

  // toggle_en[i] is 1 when every stage below i is 1, i.e. when the carry
  // into stage i is set; stage 0 always toggles.
  logic [WIDTH-1:0] toggle_en;

  assign toggle_en[0] = 1'b1;

  genvar i;
  generate
    for (i = 1; i < WIDTH; i++) begin : g_chain
      assign toggle_en[i] = toggle_en[i-1] & Q[i-1];
    end

    for (i = 0; i < WIDTH; i++) begin : g_stage
      counter_tff u_tff (
        .clock    (clock),
        .clear    (clear),
        .toggle_i (toggle_en[i]),
        .q_o      (Q[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_counter.sv
// tb/tb_counter.sv - self-checking bench for counter against an arithmetic model

module tb_counter;

  localparam int WIDTH = 4;
  localparam int MODULUS = 1 << WIDTH;

  logic             clock;
  logic             clear;
  logic [WIDTH-1:0] q;

  int checks;
  int errors;
  int model;

  counter #(.WIDTH(WIDTH)) dut (
    .Q     (q),
    .clock (clock),
    .clear (clear)
  );

  initial begin
    clock = 1'b0;
    forever #10 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [WIDTH-1:0] obs,
                          input logic [WIDTH-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", tag, $time, obs, exp);
    end
  endtask

  // One falling edge with the model advanced from the clear level sampled there.
  task automatic edge_and_check(input string tag);
    @(negedge clock);
    model = clear ? 0 : (model + 1) % MODULUS;
    #1;
    check_eq(tag, q, model[WIDTH-1:0]);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model  = 0;
    clear  = 1'b1;

    // Reset: first falling edge at t=20 with clear high.
    edge_and_check("reset");
    #13;                                  // t=34
    clear = 1'b0;

    // Count-up to 1010 at t=220.
    for (int k = 0; k < 10; k++) edge_and_check("count_up");
    check_eq("count_up_final", q, 4'b1010);

    #13;                                  // t=234
    clear = 1'b1;
    for (int k = 0; k < 3; k++) edge_and_check("mid_clear");
    check_eq("mid_clear_held", q, 4'b0000);

    #3;                                   // t=284
    clear = 1'b0;
    for (int k = 0; k < 5; k++) edge_and_check("resume");
    check_eq("resume_final", q, 4'b0101);

    // Wrap: start from zero, 16 edges.
    #3;
    clear = 1'b1;
    edge_and_check("wrap_clear");
    #3;
    clear = 1'b0;
    for (int k = 1; k <= MODULUS; k++) begin
      edge_and_check("wrap");
      if (k == MODULUS - 1) check_eq("wrap_top", q, 4'b1111);
    end
    check_eq("wrap_zero", q, 4'b0000);

    // Rising-edge immunity: clear pulsed only between rising and falling edge.
    for (int k = 0; k < 6; k++) begin
      @(posedge clock);
      #2 clear = 1'b1;
      #4 clear = 1'b0;
      edge_and_check("rise_immune");
    end

    // Randomized clear pattern with occasional mid-cycle glitches.
    for (int k = 0; k < 300; k++) begin
      @(posedge clock);
      #3;
      clear = ($urandom_range(0, 7) == 0);
      if (!clear && ($urandom_range(0, 3) == 0)) begin
        #2 clear = 1'b1;
        #2 clear = 1'b0;
      end
      edge_and_check("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
